restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//  Sequential radix-2 restoring divider. It is the inverse of the team's
//  shift-add multiplier and uses the same vld/result_vld handshake.
//  Computes q = a / b and r = a % b, retiring one quotient bit per cycle.
//  Sits beside the multiplier in the arithmetic unit, so benches can
//  round-trip multiply->divide.
// PARAMETERS
//  W  16  dividend/quotient width (W >= 2)
//  N  4   divisor/remainder width (1 <= N <= W)
// PORTS
//  clk         in   1  single clock; all state updates on posedge
//  rst_n       in   1  asynchronous, active-low reset
//  a           in   W  dividend, unsigned; sampled only on the capture edge
//  b           in   N  divisor, unsigned; sampled only on the capture edge
//  vld         in   1  request; level, held high by requester until result_vld
//  q           out  W  quotient
//  r           out  N  remainder
//  result_vld  out  1  one-cycle pulse: q/r/div_by_zero valid
//  div_by_zero out  1  result was produced with b == 0
// BEHAVIOUR
//  Reset (async assert, sync release): state = IDLE;
//   q = 0, r = 0, result_vld = 0, div_by_zero = 0; internal count = 0.
//  States: IDLE -> BUSY -> DONE -> HOLD -> IDLE.
//  IDLE: on posedge with vld = 1, capture a into the dividend shift reg
//   and b into the divisor reg. Clear the partial remainder (N+1 bits).
//   - b != 0: go to BUSY, count = 0.
//   - b == 0: go to DONE directly; q = all ones; r = a[N-1:0];
//     div_by_zero = 1.
//  BUSY, each edge:
//   - rem' = {rem[N-1:0], dividend MSB}; shift the dividend left.
//   - If rem' >= {1'b0, divisor}: rem = rem' - divisor; shift 1 into q.
//   - Else: rem = rem'; shift 0 into q.
//   - count++. After the W-th BUSY edge (count == W-1), go to DONE.
//  DONE: result_vld = 1 for exactly this one cycle (registered output).
//   q/r are final. Next edge goes to HOLD.
//  HOLD: wait until vld = 0, then go to IDLE. A vld still high after
//   result_vld never starts a second division.
//  Latency: W+1 cycles from the capture edge to the result_vld cycle
//   (17 for W=16). b == 0: 1 cycle.
//  q, r, div_by_zero hold their values until the next capture edge.
//   div_by_zero clears on the next capture with b != 0.
//  a/b changes while BUSY are ignored. vld dropping while BUSY does not
//   abort; the result still pulses, then the block returns via HOLD.
//  Reset mid-operation: immediate return to reset values. No result_vld
//   is produced for the aborted request.
//  Invariants on every result_vld with b != 0:
//   q*b + r == a and r < b.
//   Internal partial remainder is N+1 bits, so the compare never overflows.
// TESTING
//  1 W=16,N=4: a=100, b=7, vld held -> result_vld 17 cycles after capture;
//    q=14, r=2, dbz=0.
//  2 a=65535, b=15 -> q=4369, r=0. Then a=5, b=9 -> q=0, r=5
//    (divisor larger than dividend).
//  3 a=1234, b=0 -> result_vld on the next cycle; q=16'hFFFF, r=4'd2,
//    dbz=1. A following a=8, b=2 -> q=4, r=0, dbz=0.
//  4 Hold vld high for 5 cycles after result_vld -> exactly one pulse.
//    Drop vld, then reassert -> new capture.
//  5 Pull rst_n low at cycle 8 of BUSY -> outputs zero asynchronously and
//    no pulse appears. After release, a=77, b=3 -> q=25, r=2.
//  6 Sweep: all b in 1..15, a from 0..65535 (random sample, plus 0, 1,
//    65535, multiples of b) -> check q*b + r == a and r < b. Assertion
//    failure ends the sim.

Source files
------------

// File: rtl/restoring_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, q = a / b, r = a % b.
// Latency W+1 edges from capture to result_vld (1 for b == 0); vld is a held level, re-armed only after it drops.
module restoring_divider #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [N-1:0] b,
    input  logic         vld,
    output logic [W-1:0] q,
    output logic [N-1:0] r,
    output logic         result_vld,
    output logic         div_by_zero
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   dvd;
    logic [N-1:0]   dvs;
    logic [N:0]     rem;
    logic [CW-1:0]  count;
    logic [N:0]     rem_sh;
    logic [N:0]     rem_new;
    logic           fits;
    logic           last_step;
    logic           start;

    // Partial remainder carries one extra bit so the trial compare cannot overflow.
    always_comb begin
        rem_sh    = {rem[N-1:0], dvd[W-1]};
        fits      = (rem_sh >= {1'b0, dvs});
        rem_new   = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
        last_step = (count == CW'(W - 1));
        start     = (state == IDLE) && vld;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (vld) state_nxt = (b == '0) ? DONE : BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: state_nxt = HOLD;
            HOLD: if (!vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            count       <= '0;
            q           <= '0;
            r           <= '0;
            result_vld  <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // DONE always lasts one cycle, so entering it yields a single pulse.
            result_vld <= (state != DONE) && (state_nxt == DONE);
            if (start) begin
                dvd   <= a;
                dvs   <= b;
                rem   <= '0;
                count <= '0;
                if (b == '0) begin
                    q           <= '1;
                    r           <= a[N-1:0];
                    div_by_zero <= 1'b1;
                end else begin
                    q           <= '0;
                    div_by_zero <= 1'b0;
                end
            end else if (state == BUSY) begin
                dvd   <= {dvd[W-2:0], 1'b0};
                rem   <= rem_new;
                q     <= {q[W-2:0], fits};
                count <= count + CW'(1);
                if (last_step) r <= rem_new[N-1:0];
            end
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider (W=16, N=4) with hand-computed results.
module tb_restoring_divider;
    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         vld = 1'b0;
    logic [W-1:0] q;
    logic [N-1:0] r;
    logic         result_vld;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    restoring_divider #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .vld(vld),
        .q(q), .r(r), .result_vld(result_vld), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Issues one request, measures edges from capture (counted as 1) to result_vld,
    // keeps vld high for `extra` cycles afterwards, then drops it and returns to IDLE.
    task automatic divide(input logic [W-1:0] da, input logic [N-1:0] db, input int extra,
                          output logic [W-1:0] gq, output logic [N-1:0] gr,
                          output logic gz, output int lat);
        int  pulses;
        bit  seen;
        @(negedge clk);
        a = da; b = db; vld = 1'b1;
        @(posedge clk);
        #1;
        a = ~da; b = ~db;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_vld) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("result_timeout", 32'(seen), 32'd1);
        gq = q; gr = r; gz = div_by_zero;
        pulses = 0;
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            if (result_vld) pulses++;
        end
        if (extra > 0) check("single_pulse", pulses, 0);
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
    endtask

    logic [W-1:0] gq;
    logic [N-1:0] gr;
    logic         gz;
    int           lat;
    int           stray;
    int           va;

    initial begin
        #2 rst_n = 1'b0;
        #3;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_vld", result_vld, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        divide(16'd100, 4'd7, 0, gq, gr, gz, lat);
        check("t1_lat", lat, 17);
        check("t1_q", gq, 14);
        check("t1_r", gr, 2);
        check("t1_dbz", gz, 0);

        divide(16'd65535, 4'd15, 0, gq, gr, gz, lat);
        check("t2a_q", gq, 4369);
        check("t2a_r", gr, 0);
        divide(16'd5, 4'd9, 0, gq, gr, gz, lat);
        check("t2b_q", gq, 0);
        check("t2b_r", gr, 5);

        divide(16'd1234, 4'd0, 0, gq, gr, gz, lat);
        check("t3a_lat", lat, 1);
        check("t3a_q", gq, 16'hFFFF);
        check("t3a_r", gr, 2);
        check("t3a_dbz", gz, 1);
        divide(16'd8, 4'd2, 0, gq, gr, gz, lat);
        check("t3b_q", gq, 4);
        check("t3b_r", gr, 0);
        check("t3b_dbz", gz, 0);

        divide(16'd300, 4'd11, 5, gq, gr, gz, lat);
        check("t4a_q", gq, 27);
        check("t4a_r", gr, 3);
        divide(16'd50, 4'd6, 0, gq, gr, gz, lat);
        check("t4b_lat", lat, 17);
        check("t4b_q", gq, 8);
        check("t4b_r", gr, 2);

        // Abort a division part-way through BUSY.
        @(negedge clk);
        a = 16'd65535; b = 4'd1; vld = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        vld   = 1'b0;
        #1;
        check("t5_q", q, 0);
        check("t5_r", r, 0);
        check("t5_vld", result_vld, 0);
        check("t5_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (result_vld) stray++;
        end
        check("t5_no_pulse", stray, 0);
        divide(16'd77, 4'd3, 0, gq, gr, gz, lat);
        check("t5_q2", gq, 25);
        check("t5_r2", gr, 2);

        for (int db = 1; db < 16; db++) begin
            for (int j = 0; j < 7; j++) begin
                case (j)
                    0:       va = 0;
                    1:       va = 1;
                    2:       va = 65535;
                    3, 4:    va = db * $urandom_range(0, 65535 / db);
                    default: va = $urandom_range(0, 65535);
                endcase
                divide(W'(va), N'(db), 0, gq, gr, gz, lat);
                check("sweep_inv", int'(gq) * db + int'(gr), va);
                check("sweep_r_lt_b", 32'(int'(gr) < db), 32'd1);
                check("sweep_q", gq, va / db);
                check("sweep_dbz", gz, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
